// File: rtl/bp_fe_queue_ckpt_fifo_if.sv
// FE/BE handshake bundle for the checkpointed fetch queue.
// The slave modport is the queue itself; the master modport is the FE/BE side.
interface bp_fe_queue_ckpt_fifo_if #(
    parameter int data_width_p = 64
);
    // FE enqueue side
    logic [data_width_p-1:0] fe_queue_i;
    logic                    fe_queue_v_i;
    logic                    fe_queue_ready_o;

    // BE read / retire / rewind side
    logic [data_width_p-1:0] fe_queue_o;
    logic                    fe_queue_v_o;
    logic                    fe_queue_yumi_i;
    logic                    fe_queue_deq_i;
    logic                    fe_queue_roll_i;
    logic                    fe_queue_clr_i;

    // status
    logic                    empty_o;

    modport slave (
        input  fe_queue_i, fe_queue_v_i,
        output fe_queue_ready_o,
        output fe_queue_o, fe_queue_v_o,
        input  fe_queue_yumi_i, fe_queue_deq_i, fe_queue_roll_i, fe_queue_clr_i,
        output empty_o
    );

    modport master (
        output fe_queue_i, fe_queue_v_i,
        input  fe_queue_ready_o,
        input  fe_queue_o, fe_queue_v_o,
        output fe_queue_yumi_i, fe_queue_deq_i, fe_queue_roll_i, fe_queue_clr_i,
        input  empty_o
    );
endinterface

// File: rtl/bp_fe_queue_ckpt_fifo.sv
// Checkpointed FIFO between FE fetch and BE checker.
// Three pointers: wptr (write), rptr (speculative read), cptr (commit).
// Storage is released only on deq, so roll can always replay from cptr.
module bp_fe_queue_ckpt_fifo #(
    parameter int els_p        = 8,
    parameter int data_width_p = 64
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    bp_fe_queue_ckpt_fifo_if.slave fe_if
);
    localparam int idx_w_lp = $clog2(els_p);
    localparam int ptr_w_lp = idx_w_lp + 1;

    typedef logic [ptr_w_lp-1:0] ptr_t;

    ptr_t wptr, rptr, cptr;
    ptr_t wptr_n, rptr_n, cptr_n;

    logic [data_width_p-1:0] mem [els_p];

    logic [idx_w_lp-1:0] widx, ridx, cidx;
    logic                full;
    logic                enq;
    logic                mem_we;
    ptr_t                occupancy;
    ptr_t                popped;

    assign widx = wptr[idx_w_lp-1:0];
    assign ridx = rptr[idx_w_lp-1:0];
    assign cidx = cptr[idx_w_lp-1:0];

    // Same index with opposite wrap bits means every slot is owned by an unretired packet.
    assign full = (widx == cidx) & (wptr[ptr_w_lp-1] != cptr[ptr_w_lp-1]);

    // Status outputs come only from registers and reset_i, so none of the BE
    // commands can combinationally affect what FE sees this cycle.
    assign fe_if.fe_queue_ready_o = ~full & ~reset_i;
    assign fe_if.fe_queue_v_o     = (rptr != wptr);
    assign fe_if.empty_o          = (wptr == cptr);
    assign fe_if.fe_queue_o       = mem[ridx];

    assign enq    = fe_if.fe_queue_v_i & fe_if.fe_queue_ready_o;
    // A clr in the same cycle wipes the packet, so it must not land in storage either.
    assign mem_we = enq & ~fe_if.fe_queue_clr_i;

    // Next-pointer selection: deq first advances the commit point, then clr/roll/normal flow.
    always_comb begin
        cptr_n = cptr + ptr_t'(fe_if.fe_queue_deq_i);
        wptr_n = wptr;
        rptr_n = rptr;
        if (fe_if.fe_queue_clr_i) begin
            wptr_n = cptr_n;
            rptr_n = cptr_n;
        end else if (fe_if.fe_queue_roll_i) begin
            rptr_n = cptr_n;
            if (enq)
                wptr_n = wptr + ptr_t'(1);
        end else begin
            if (enq)
                wptr_n = wptr + ptr_t'(1);
            if (fe_if.fe_queue_yumi_i)
                rptr_n = rptr + ptr_t'(1);
        end
    end

    // Pointer registers; reset returns the queue to empty.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr <= '0;
            rptr <= '0;
            cptr <= '0;
        end else begin
            wptr <= wptr_n;
            rptr <= rptr_n;
            cptr <= cptr_n;
        end
    end

    // Packet storage; cleared on reset so fe_queue_o is never X.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < els_p; i++)
                mem[i] <= '0;
        end else if (mem_we) begin
            mem[widx] <= fe_if.fe_queue_i;
        end
    end

    // Distances from the commit point, used only by the protocol checks below.
    assign occupancy = wptr - cptr;
    assign popped    = rptr - cptr;

    // Retiring needs at least one popped, unretired packet.
    a_deq_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        fe_if.fe_queue_deq_i |-> (cptr != rptr));

    // Popping needs a visible packet.
    a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        fe_if.fe_queue_yumi_i |-> fe_if.fe_queue_v_o);

    // cptr <= rptr <= wptr in modular order, and never more than els_p live entries.
    a_ptr_order: assert property (@(posedge clk_i) disable iff (reset_i)
        (popped <= occupancy) && (occupancy <= ptr_t'(els_p)));

endmodule

// File: tb/tb_bp_fe_queue_ckpt_fifo.sv
// Directed + random bench for bp_fe_queue_ckpt_fifo against a queue-level model.
module tb_bp_fe_queue_ckpt_fifo;
    localparam int ELS = 8;
    localparam int DW  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_fe_queue_ckpt_fifo_if #(.data_width_p(DW)) qif ();

    bp_fe_queue_ckpt_fifo #(.els_p(ELS), .data_width_p(DW)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .fe_if   (qif)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: packets from the commit point onward, plus count of popped-unretired ones.
    logic [DW-1:0] mq[$];
    int            npop = 0;
    bit            model_live = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance the model by one clock using the inputs held across this edge.
    always @(posedge clk) begin
        bit en;
        if (rst) begin
            mq.delete();
            npop = 0;
        end else begin
            en = qif.fe_queue_v_i && (mq.size() < ELS);
            if (qif.fe_queue_deq_i && mq.size() > 0) begin
                void'(mq.pop_front());
                npop--;
            end
            if (qif.fe_queue_clr_i) begin
                mq.delete();
                npop = 0;
            end else if (qif.fe_queue_roll_i) begin
                npop = 0;
                if (en) mq.push_back(qif.fe_queue_i);
            end else begin
                if (en) mq.push_back(qif.fe_queue_i);
                if (qif.fe_queue_yumi_i) npop++;
            end
        end
        model_live = 1;
    end

    // Every cycle, compare all outputs against the model on the falling edge.
    always @(negedge clk) begin
        if (model_live) begin
            chk("ready_o", {63'd0, qif.fe_queue_ready_o}, {63'd0, (mq.size() < ELS) && !rst});
            chk("v_o",     {63'd0, qif.fe_queue_v_o},     {63'd0, npop < mq.size()});
            chk("empty_o", {63'd0, qif.empty_o},          {63'd0, mq.size() == 0});
            if (npop < mq.size())
                chk("fe_queue_o", qif.fe_queue_o, mq[npop]);
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic y,
                        input logic dq, input logic rl, input logic cl);
        qif.fe_queue_v_i    = v;
        qif.fe_queue_i      = d;
        qif.fe_queue_yumi_i = y;
        qif.fe_queue_deq_i  = dq;
        qif.fe_queue_roll_i = rl;
        qif.fe_queue_clr_i  = cl;
        @(posedge clk); #1;
        qif.fe_queue_v_i    = 1'b0;
        qif.fe_queue_yumi_i = 1'b0;
        qif.fe_queue_deq_i  = 1'b0;
        qif.fe_queue_roll_i = 1'b0;
        qif.fe_queue_clr_i  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step(0, '0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    localparam logic [DW-1:0] PA = 64'hAAAA_0000_0000_000A;
    localparam logic [DW-1:0] PB = 64'hBBBB_0000_0000_000B;
    localparam logic [DW-1:0] PC = 64'hCCCC_0000_0000_000C;
    localparam logic [DW-1:0] PD = 64'hDDDD_0000_0000_000D;
    localparam logic [DW-1:0] PE = 64'hEEEE_0000_0000_000E;
    localparam logic [DW-1:0] PF = 64'hFFFF_0000_0000_000F;
    localparam logic [DW-1:0] PG = 64'h6666_0000_0000_0006;
    localparam logic [DW-1:0] PH = 64'h4848_0000_0000_0008;
    localparam logic [DW-1:0] PX = 64'h0909_0909_0909_0909;

    initial begin
        qif.fe_queue_i      = '0;
        qif.fe_queue_v_i    = 1'b0;
        qif.fe_queue_yumi_i = 1'b0;
        qif.fe_queue_deq_i  = 1'b0;
        qif.fe_queue_roll_i = 1'b0;
        qif.fe_queue_clr_i  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, qif.fe_queue_ready_o}, 64'd0);
        chk("rst_v",     {63'd0, qif.fe_queue_v_o},     64'd0);
        chk("rst_empty", {63'd0, qif.empty_o},          64'd1);
        chk("rst_data",  qif.fe_queue_o,                64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {63'd0, qif.fe_queue_ready_o}, 64'd1);

        // 1: A,B,C back to back; A visible one cycle after its handshake
        qif.fe_queue_v_i = 1'b1; qif.fe_queue_i = PA; #1;
        chk("t1_no_bypass", {63'd0, qif.fe_queue_v_o}, 64'd0);
        step(1, PA, 0, 0, 0, 0);
        chk("t1_v",     {63'd0, qif.fe_queue_v_o}, 64'd1);
        chk("t1_data",  qif.fe_queue_o, PA);
        chk("t1_empty", {63'd0, qif.empty_o}, 64'd0);
        step(1, PB, 0, 0, 0, 0);
        step(1, PC, 0, 0, 0, 0);
        chk("t1_data_hold", qif.fe_queue_o, PA);

        // 2: fill, drain speculatively, retire one, wrap
        do_reset();
        for (int i = 0; i < ELS; i++) step(1, 64'h100 + 64'(i), 0, 0, 0, 0);
        chk("t2_full_ready", {63'd0, qif.fe_queue_ready_o}, 64'd0);
        for (int i = 0; i < ELS; i++) begin
            chk("t2_pop_data", qif.fe_queue_o, 64'h100 + 64'(i));
            step(0, '0, 1, 0, 0, 0);
        end
        chk("t2_v_drained", {63'd0, qif.fe_queue_v_o}, 64'd0);
        chk("t2_ready_still0", {63'd0, qif.fe_queue_ready_o}, 64'd0);
        step(0, '0, 0, 1, 0, 0);
        chk("t2_ready_after_deq", {63'd0, qif.fe_queue_ready_o}, 64'd1);
        chk("t2_wptr_wrap", 64'(dut.wptr), 64'h8);
        step(1, PX, 0, 0, 0, 0);
        chk("t2_wptr_after9", 64'(dut.wptr), 64'h9);
        chk("t2_9th_data", qif.fe_queue_o, PX);

        // 3: roll rewinds to oldest unretired packet
        do_reset();
        step(1, PA, 0, 0, 0, 0);
        step(1, PB, 0, 0, 0, 0);
        step(1, PC, 0, 0, 0, 0);
        step(1, PD, 0, 0, 0, 0);
        repeat (3) step(0, '0, 1, 0, 0, 0);
        chk("t3_at_D", qif.fe_queue_o, PD);
        step(0, '0, 0, 1, 0, 0);
        step(0, '0, 0, 0, 1, 0);
        chk("t3_roll_B", qif.fe_queue_o, PB);
        step(0, '0, 1, 0, 0, 0);
        chk("t3_replay_C", qif.fe_queue_o, PC);
        step(0, '0, 1, 0, 0, 0);
        chk("t3_replay_D", qif.fe_queue_o, PD);
        step(0, '0, 1, 0, 0, 0);
        chk("t3_v_done", {63'd0, qif.fe_queue_v_o}, 64'd0);

        // 4: clr + deq + enq E drops E and everything unretired
        do_reset();
        step(1, PA, 0, 0, 0, 0);
        step(1, PB, 0, 0, 0, 0);
        step(1, PC, 0, 0, 0, 0);
        step(1, PD, 0, 0, 0, 0);
        repeat (2) step(0, '0, 1, 0, 0, 0);
        step(1, PE, 0, 1, 0, 1);
        chk("t4_v",     {63'd0, qif.fe_queue_v_o}, 64'd0);
        chk("t4_empty", {63'd0, qif.empty_o},      64'd1);
        step(1, PF, 0, 0, 0, 0);
        chk("t4_F", qif.fe_queue_o, PF);

        // 5: roll + yumi + enq G: yumi ignored, G appended behind F,H
        step(1, PH, 0, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        chk("t5_at_H", qif.fe_queue_o, PH);
        step(1, PG, 1, 0, 1, 0);
        chk("t5_rolled_F", qif.fe_queue_o, PF);
        step(0, '0, 1, 0, 0, 0);
        chk("t5_H", qif.fe_queue_o, PH);
        step(0, '0, 1, 0, 0, 0);
        chk("t5_G", qif.fe_queue_o, PG);
        step(0, '0, 1, 0, 0, 0);
        chk("t5_v_done", {63'd0, qif.fe_queue_v_o}, 64'd0);

        // 6: random legal traffic, with one mid-run reset
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            logic v, y, dq, rl, cl;
            if (i == 600) do_reset();
            v  = ($urandom_range(0, 99) < 60);
            y  = (npop < mq.size()) && ($urandom_range(0, 99) < 50);
            dq = (npop > 0) && ($urandom_range(0, 99) < 30);
            rl = ($urandom_range(0, 99) < 5);
            cl = ($urandom_range(0, 99) < 3);
            step(v, {$urandom, $urandom}, y, dq, rl, cl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
